// File: rtl/shift_seq.sv
// shift_seq: iterative 16-bit shifter sequencer for the ALU shift path.
// One request (operand, 4-bit amount, op) is captured and shifted through the
// power-of-two stages 8, 4, 2, 1 using a single reused stage shifter, then the
// result is registered on `out` with a one-cycle `done` pulse.
//
// Build option: define SHIFT_SEQ_SKIP_EN to apply only the set bits of the
// amount (latency max(popcount(cnt), 1) edges). Default is a fixed 4-edge walk.
module shift_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [1:0] OpRol = 2'b00;
  localparam logic [1:0] OpSll = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpSrl = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] out_q, out_d;

  logic [1:0]  stage_k;    // exponent of the stage considered this edge
  logic        stage_en;   // stage actually shifts (its mask bit is set)
  logic        stage_last; // this SHIFT edge completes the request
  logic [3:0]  mask_nxt;
  logic [3:0]  amt;
  logic [15:0] stage_res;

`ifdef SHIFT_SEQ_SKIP_EN
  // Pick the highest remaining mask bit; an empty mask is a pass-through edge.
  always_comb begin
    stage_k  = 2'd0;
    stage_en = 1'b0;
    if (mask_q[3]) begin
      stage_k  = 2'd3;
      stage_en = 1'b1;
    end else if (mask_q[2]) begin
      stage_k  = 2'd2;
      stage_en = 1'b1;
    end else if (mask_q[1]) begin
      stage_k  = 2'd1;
      stage_en = 1'b1;
    end else if (mask_q[0]) begin
      stage_k  = 2'd0;
      stage_en = 1'b1;
    end
    mask_nxt   = stage_en ? (mask_q & ~(4'd1 << stage_k)) : mask_q;
    stage_last = (mask_nxt == 4'd0);
  end
`else
  logic [1:0] stage_q, stage_d;

  // Walk k = 3, 2, 1, 0 unconditionally; the mask only gates each stage.
  always_comb begin
    stage_k    = stage_q;
    stage_en   = mask_q[stage_q];
    mask_nxt   = mask_q;
    stage_last = (stage_q == 2'd0);
  end

  // Stage pointer reloads to 3 on every accepted request.
  always_comb begin
    stage_d = stage_q;
    if ((state_q == StIdle || state_q == StDone) && start) begin
      stage_d = 2'd3;
    end else if (state_q == StShift) begin
      stage_d = stage_q - 2'd1;
    end
  end

  // Stage pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'd0;
    end else begin
      stage_q <= stage_d;
    end
  end
`endif

  assign amt = stage_en ? (4'd1 << stage_k) : 4'd0;

  // Single shared stage shifter, amount 0 or 2^k.
  always_comb begin
    stage_res = acc_q;
    unique case (op_q)
      OpRol:   stage_res = (acc_q << amt) | (acc_q >> (5'd16 - {1'b0, amt}));
      OpSll:   stage_res = acc_q << amt;
      OpSra:   stage_res = $unsigned($signed(acc_q) >>> amt);
      OpSrl:   stage_res = acc_q >> amt;
      default: stage_res = acc_q;
    endcase
  end

  // Sequencer next state: accept in IDLE/DONE, step stages in SHIFT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    op_d    = op_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          acc_d   = in;
          mask_d  = cnt;
          op_d    = op;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d  = stage_res;
        mask_d = mask_nxt;
        if (stage_last) begin
          out_d   = stage_res;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      mask_q  <= 4'd0;
      op_q    <= OpRol;
      out_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    out  = out_q;
  end

endmodule
